// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S frame geometry and the stereo sample pair type
package i2s_pkg;
    localparam int SAMPLE_W       = 24;
    localparam int SLOT_BCK       = 32;
    localparam int FRAME_BCK      = 64;
    localparam int DATA_FIRST_POS = 1;
    localparam int DATA_LAST_POS  = 24;
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides MCK into registered BCK/LRCK and exposes the BCK-fall strobe and bit position
module i2s_clk_gen #(
    parameter int MCK_PER_BCK = 4
) (
    input  logic       i_mck,
    input  logic       i_rst,
    output logic       o_bck,
    output logic       o_lrck,
    output logic       bck_fall,
    output logic [5:0] bit_cnt
);
    localparam int DW = $clog2(MCK_PER_BCK);
    logic [DW-1:0] div_cnt, div_nxt;
    logic [5:0] bit_nxt;
    always_comb begin
        bck_fall = div_cnt == DW'(MCK_PER_BCK - 1);
        div_nxt  = bck_fall ? '0 : div_cnt + 1'b1;
        bit_nxt  = bck_fall ? bit_cnt + 6'd1 : bit_cnt;
    end
    // BCK and LRCK are registered from the next-state values so they move on the same edge as the counters
    always_ff @(posedge i_mck) begin
        if (i_rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            o_bck   <= 1'b0;
            o_lrck  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            o_bck   <= div_nxt >= DW'(MCK_PER_BCK / 2);
            o_lrck  <= bit_nxt[5];
        end
    end
endmodule

// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S bus master transmitter with a one-entry holding register feeding 64-BCK stereo frames
module i2s_master_tx
    import i2s_pkg::*;
#(
    parameter int MCK_PER_BCK = 4
) (
    input  logic                i_mck,
    input  logic                i_rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                o_bck,
    output logic                o_lrck,
    output logic                o_data,
    output logic                o_frame_start,
    output logic                o_underrun
);
    logic bck_fall, load, wr, bit_val;
    logic [5:0] bit_cnt, bit_nxt;
    logic [4:0] pos;
    logic hold_full;
    sample_pair_t hold, frame;
    logic [SAMPLE_W-1:0] word;
    i2s_clk_gen #(.MCK_PER_BCK(MCK_PER_BCK)) u_clk_gen (
        .i_mck    (i_mck),
        .i_rst    (i_rst),
        .o_bck    (o_bck),
        .o_lrck   (o_lrck),
        .bck_fall (bck_fall),
        .bit_cnt  (bit_cnt)
    );
    // o_data is registered on the BCK fall, so the mux looks at the position being entered
    always_comb begin
        s_ready = !hold_full && !i_rst;
        wr      = s_valid && s_ready;
        load    = bck_fall && bit_cnt == 6'(FRAME_BCK - 1);
        bit_nxt = bit_cnt + 6'd1;
        pos     = bit_nxt[4:0];
        word    = bit_nxt[5] ? frame.right : frame.left;
        bit_val = (pos >= 5'(DATA_FIRST_POS) && pos <= 5'(DATA_LAST_POS)) ? word[5'(SAMPLE_W) - pos] : 1'b0;
    end
    always_ff @(posedge i_mck) begin
        if (i_rst) begin
            hold_full     <= 1'b0;
            hold          <= '0;
            frame         <= '0;
            o_data        <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            o_frame_start <= load;
            o_underrun    <= load && !hold_full;
            hold_full     <= wr || (hold_full && !load);
            if (load) frame <= hold_full ? hold : '0;
            if (wr) hold <= '{left: s_left, right: s_right};
            if (bck_fall) o_data <= bit_val;
        end
    end
endmodule
